// File: rtl/pc_unit_if.sv
// Bus between the control FSM and the program-counter unit.
// Optional PREV signal present when PC_PREV_EN is defined.
interface pc_unit_if #(
    parameter int N = 5
);
    // Handshake: PCW is a one-cycle valid qualifying SEL/TGT on the rising
    // CLK edge; there is no ready, the unit accepts every PCW=1 cycle.
    logic         PCW;
    logic [1:0]   SEL;
    logic [N-1:0] TGT;
    logic [N-1:0] PC;
    logic         RAS_EMPTY;
    logic         RAS_FULL;
    logic         OVF;
    logic         UNF;
`ifdef PC_PREV_EN
    logic [N-1:0] PREV;
`endif

    modport master (
        output PCW,
        output SEL,
        output TGT,
        input  PC,
        input  RAS_EMPTY,
        input  RAS_FULL,
        input  OVF,
        input  UNF
`ifdef PC_PREV_EN
        , input PREV
`endif
    );

    modport slave (
        input  PCW,
        input  SEL,
        input  TGT,
        output PC,
        output RAS_EMPTY,
        output RAS_FULL,
        output OVF,
        output UNF
`ifdef PC_PREV_EN
        , output PREV
`endif
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with INC/LOAD/CALL/RET modes and a circular return-address stack.
// Define PC_PREV_EN to add the PREV register (PC before the latest update).
module pc_unit #(
    parameter int N         = 5,
    parameter int RST_VEC   = 15,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input logic        CLK,
    input logic        RST,
    pc_unit_if.slave   bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        SEL_INC  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_CALL = 2'b10,
        SEL_RET  = 2'b11
    } sel_e;

    logic [N-1:0]  pc_q, pc_d, pc_plus;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_q, top_d, ptr_next, ptr_prev;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push;
    logic          empty, full;
    logic [N-1:0]  ras [RAS_DEPTH];

    assign pc_plus  = pc_q + N'(STEP);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(RAS_DEPTH));
    assign ptr_next = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
    assign ptr_prev = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        top_d = top_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (bus.PCW) begin
            case (sel_e'(bus.SEL))
                SEL_INC:  pc_d = pc_plus;
                SEL_LOAD: pc_d = bus.TGT;
                SEL_CALL: begin
                    // When full, the slot after top holds the oldest entry, so
                    // advancing top overwrites it and the count stays saturated.
                    pc_d  = bus.TGT;
                    push  = 1'b1;
                    top_d = ptr_next;
                    if (full) ovf_d = 1'b1;
                    else      cnt_d = cnt_q + 1'b1;
                end
                SEL_RET: begin
                    if (empty) begin
                        pc_d  = N'(RST_VEC);
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = ras[top_q];
                        top_d = ptr_prev;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= N'(RST_VEC);
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge CLK) begin
        if (push && !RST) ras[ptr_next] <= pc_plus;
    end

`ifdef PC_PREV_EN
    logic [N-1:0] prev_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          prev_q <= N'(RST_VEC);
        else if (bus.PCW) prev_q <= pc_q;
    end
    assign bus.PREV = prev_q;
`endif

    assign bus.PC        = pc_q;
    assign bus.RAS_EMPTY = empty;
    assign bus.RAS_FULL  = full;
    assign bus.OVF       = ovf_q;
    assign bus.UNF       = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: driver pushes expected state, monitor pops and compares.
// Expected PREV is also checked when PC_PREV_EN is defined.
module tb_pc_unit;
    localparam int N = 5;
`ifdef PC_PREV_EN
    localparam int W = 2 * N + 4;
`else
    localparam int W = N + 4;
`endif
    localparam logic [1:0] INC = 2'b00, LD = 2'b01, CL = 2'b10, RT = 2'b11;

    logic clk;
    logic rst;
    pc_unit_if #(.N(N)) bus ();

    pc_unit #(.N(N), .RST_VEC(15), .STEP(1), .RAS_DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           vec_id = 0;

    function automatic logic [W-1:0] observed();
`ifdef PC_PREV_EN
        return {bus.PREV, bus.PC, bus.RAS_EMPTY, bus.RAS_FULL, bus.OVF, bus.UNF};
`else
        return {bus.PC, bus.RAS_EMPTY, bus.RAS_FULL, bus.OVF, bus.UNF};
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [W-1:0] want, got;
            int           id;
            want = exp_q.pop_front();
            id   = id_q.pop_front();
            got  = observed();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL vec%0d state got=%h want=%h (PC got %0d want %0d)",
                         id, got, want, got[N+3:4], want[N+3:4]);
            end
        end
    end

    // driver: apply one cycle of stimulus and queue the state expected after the edge
    task automatic step(input logic r, input logic pcw, input logic [1:0] sel,
                        input logic [N-1:0] tgt, input logic [N-1:0] epc,
                        input logic ee, input logic ef, input logic eo, input logic eu,
                        input logic [N-1:0] eprev);
        @(negedge clk);
        rst     = r;
        bus.PCW = pcw;
        bus.SEL = sel;
        bus.TGT = tgt;
`ifdef PC_PREV_EN
        exp_q.push_back({eprev, epc, ee, ef, eo, eu});
`else
        exp_q.push_back({epc, ee, ef, eo, eu});
        if (eprev != eprev) $display("unreachable");
`endif
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    initial begin
        rst     = 1'b1;
        bus.PCW = 1'b0;
        bus.SEL = 2'b00;
        bus.TGT = '0;

        // 1: reset overrides PCW=1 LOAD, then one INC
        step(1, 1, LD, 3,   15, 1, 0, 0, 0, 15);
        step(0, 1, INC, 0,  16, 1, 0, 0, 0, 15);
        // 2: LOAD 31, INC wraps silently, PCW=0 holds (stray CALL/LOAD ignored)
        step(0, 1, LD, 31,  31, 1, 0, 0, 0, 16);
        step(0, 1, INC, 0,   0, 1, 0, 0, 0, 31);
        step(0, 0, CL, 9,    0, 1, 0, 0, 0, 31);
        step(0, 0, LD, 9,    0, 1, 0, 0, 0, 31);
        step(0, 0, RT, 9,    0, 1, 0, 0, 0, 31);
        // 3: CALL from 4, two INCs, RET to 5
        step(0, 1, LD, 4,    4, 1, 0, 0, 0, 0);
        step(0, 1, CL, 20,  20, 0, 0, 0, 0, 4);
        step(0, 1, INC, 0,  21, 0, 0, 0, 0, 20);
        step(0, 1, INC, 0,  22, 0, 0, 0, 0, 21);
        step(0, 1, RT, 0,    5, 1, 0, 0, 0, 22);
        // 4: five nested CALLs overflow, five RETs end in underflow
        step(1, 0, INC, 0,  15, 1, 0, 0, 0, 15);
        step(0, 1, LD, 1,    1, 1, 0, 0, 0, 15);
        step(0, 1, CL, 2,    2, 0, 0, 0, 0, 1);
        step(0, 1, CL, 3,    3, 0, 0, 0, 0, 2);
        step(0, 1, CL, 4,    4, 0, 0, 0, 0, 3);
        step(0, 1, CL, 5,    5, 0, 1, 0, 0, 4);
        step(0, 1, CL, 6,    6, 0, 1, 1, 0, 5);
        step(0, 1, RT, 0,    6, 0, 0, 1, 0, 6);
        step(0, 1, RT, 0,    5, 0, 0, 1, 0, 6);
        step(0, 1, RT, 0,    4, 0, 0, 1, 0, 5);
        step(0, 1, RT, 0,    3, 1, 0, 1, 0, 4);
        step(0, 1, RT, 0,   15, 1, 0, 1, 1, 3);
        // 5: RET on empty after reset, then CALL still pushes, UNF sticks
        step(1, 0, INC, 0,  15, 1, 0, 0, 0, 15);
        step(0, 1, RT, 0,   15, 1, 0, 0, 1, 15);
        step(0, 1, CL, 9,    9, 0, 0, 0, 1, 15);
        step(0, 1, RT, 0,   16, 1, 0, 0, 1, 9);
        // reset between CALL and RET empties the stack
        step(0, 1, CL, 12,  12, 0, 0, 0, 1, 16);
        step(1, 1, RT, 0,   15, 1, 0, 0, 0, 15);
        step(0, 1, RT, 0,   15, 1, 0, 0, 1, 15);
        // 6: PREV tracking (PREV checked only with PC_PREV_EN)
        step(0, 1, LD, 7,    7, 1, 0, 0, 1, 15);
        step(0, 1, INC, 0,   8, 1, 0, 0, 1, 7);
        step(0, 0, INC, 0,   8, 1, 0, 0, 1, 7);
        step(0, 0, LD, 30,   8, 1, 0, 0, 1, 7);

        @(negedge clk);
        bus.PCW = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multicycle datapath. It replaces the plain load-only PC register with four next-PC modes: increment, branch/jump load, call and return. Call and return use an internal return-address stack (RAS). The unit sits between the control FSM (which drives PCW/SEL) and the instruction-memory address port.

Parameters:
N, 5, address width in bits (PC, TGT, stack entries)
RST_VEC, 15, PC value loaded on reset and on return-underflow
STEP, 1, increment added to PC in sequential/call modes
RAS_DEPTH, 4, number of return-address stack entries (>=1)

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  reset, asynchronous, active-high
PCW  input  1  PC write enable; when 0 the unit holds all state
SEL  input  2  next-PC mode: 00 INC, 01 LOAD, 10 CALL, 11 RET
TGT  input  N  target address for LOAD/CALL
PC  output  N  current program counter (registered)
RAS_EMPTY  output  1  stack holds 0 entries
RAS_FULL  output  1  stack holds RAS_DEPTH entries
OVF  output  1  sticky: a CALL was issued while the stack was full
UNF  output  1  sticky: a RET was issued while the stack was empty

Behaviour:
- Reset: RST is asynchronous, active-high, clock CLK, and overrides every other input, including PCW=1 in the same cycle. On reset: PC=RST_VEC, stack count=0, RAS_EMPTY=1, RAS_FULL=0 (RAS_FULL=1 only if RAS_DEPTH=0, which is illegal), OVF=0, UNF=0. Stack entry contents are don't-care.
- All updates occur on the rising CLK edge with PCW=1. Outputs are registered, so the new PC is visible one cycle after the qualifying edge; there is no combinational path from inputs to PC.
- PCW=0: SEL and TGT are ignored; PC, stack, count and flags are unchanged.
- INC (00): PC <= (PC+STEP) mod 2^N. Wrap from 2^N-1 to 0 is silent and sets no flag.
- LOAD (01): PC <= TGT. Stack unchanged.
- CALL (10): push (PC+STEP) mod 2^N; PC <= TGT.
  - Not full: count+1.
  - Full: the oldest entry is discarded, the new entry becomes top, count stays RAS_DEPTH, and OVF <= 1.
- RET (11):
  - Not empty: PC <= top entry; count-1.
  - Empty: PC <= RST_VEC, count stays 0, UNF <= 1.
- Stack storage is a circular buffer of RAS_DEPTH entries with a top pointer. Pointer arithmetic wraps modulo RAS_DEPTH, so RAS_DEPTH need not be a power of two.
- Flags:
  - RAS_EMPTY = (count==0) and RAS_FULL = (count==RAS_DEPTH), both derived from the registered count.
  - OVF and UNF remain set until RST.
- A CALL immediately followed by a RET returns to (call-site PC + STEP), independent of TGT.
- Reset mid-sequence (e.g. between a CALL and its RET) empties the stack. A RET issued after that reset underflows.

Optional Feature:
Macro PC_PREV_EN.
- Defined: adds output PREV (N bits), which holds the PC value before the most recent PCW=1 update. PREV is loaded with the old PC on every PCW=1 edge, is unchanged when PCW=0, and resets to RST_VEC. It supports branch-offset calculation and trace.
- Undefined: no PREV port and no extra register; all other behaviour is identical.

Test Plan:
Defaults N=5, RST_VEC=15, STEP=1, RAS_DEPTH=4 unless stated.
1. Assert RST while PCW=1, SEL=01, TGT=3 -> PC=15, RAS_EMPTY=1, OVF=0, UNF=0; deassert RST, one INC -> PC=16.
2. LOAD TGT=31 then INC -> PC=31 then PC=0 (wrap), no flag set; PCW=0 for 3 cycles -> PC remains 0.
3. From PC=4: CALL TGT=20, INC, INC, RET -> PC=20, 21, 22, then 5; RAS_EMPTY returns to 1.
4. Five nested CALLs from PCs 1, 2, 3, 4, 5 (each TGT=next value) -> after 4th RAS_FULL=1; 5th sets OVF=1. Five RETs -> PCs 6, 5, 4, 3, then 15 with UNF=1 (oldest return address 2 was lost).
5. RET on empty stack after reset -> PC=15, UNF=1, count 0; a following CALL still pushes normally, and UNF stays 1.
6. With PC_PREV_EN: reset -> PREV=15; LOAD 7 -> PREV=15, PC=7; INC -> PREV=7, PC=8; PCW=0 -> PREV stays 7.
